// File: rtl/board_pkg.sv
// Shared chess-board definitions: piece codes, ray directions, square helpers
// and the leaper (pawn/knight/king) target mask generator.
package board_pkg;

  localparam int PIECE_W   = 4;
  localparam int COLOR_BIT = 3;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  typedef enum logic [2:0] {
    DIR_N, DIR_E, DIR_S, DIR_W, DIR_NE, DIR_SE, DIR_SW, DIR_NW
  } dir_e;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RAY, ST_DONE} state_e;

  function automatic logic [2:0] rank_of(input logic [5:0] s);
    return s[5:3];
  endfunction

  function automatic logic [2:0] file_of(input logic [5:0] s);
    return s[2:0];
  endfunction

  // Code 7 has no piece meaning and is treated as an empty square.
  function automatic logic is_piece(input logic [2:0] kind);
    return (kind != EMPTY) && (kind != 3'd7);
  endfunction

  // One-hot square mask, or zero when (r, f) lies off the board.
  function automatic logic [63:0] bit_at(input int r, input int f);
    logic [63:0] m;
    logic [5:0]  idx;
    m   = '0;
    idx = 6'(r * 8 + f);
    if (r >= 0 && r < 8 && f >= 0 && f < 8) m[idx] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] leaper_mask(input logic [5:0] sq,
                                              input logic [2:0] kind,
                                              input logic       side);
    logic [63:0] m;
    int r, f, adr, adf;
    m = '0;
    r = int'(rank_of(sq));
    f = int'(file_of(sq));
    if (kind == PAWN) begin
      m |= bit_at(side ? r - 1 : r + 1, f - 1);
      m |= bit_at(side ? r - 1 : r + 1, f + 1);
    end else begin
      for (int dr = -2; dr <= 2; dr++) begin
        for (int df = -2; df <= 2; df++) begin
          adr = (dr < 0) ? -dr : dr;
          adf = (df < 0) ? -df : df;
          if ((kind == KNIGHT && adr * adf == 2) ||
              (kind == KING && adr <= 1 && adf <= 1 && adr + adf != 0))
            m |= bit_at(r + dr, f + df);
        end
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/square_step.sv
// One step of a sliding ray: neighbouring square in a direction, or off_board
// when the step would leave the board (including any file wrap).
module square_step
  import board_pkg::*;
(
  input  logic [5:0] square,
  input  logic [2:0] dir,
  output logic [5:0] next_square,
  output logic       off_board
);

  logic       up, down, right, left;
  logic [2:0] r, f;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    up    = 1'b0;
    down  = 1'b0;
    right = 1'b0;
    left  = 1'b0;
    case (dir_e'(dir))
      DIR_N:   up = 1'b1;
      DIR_E:   right = 1'b1;
      DIR_S:   down = 1'b1;
      DIR_W:   left = 1'b1;
      DIR_NE:  begin up = 1'b1;   right = 1'b1; end
      DIR_SE:  begin down = 1'b1; right = 1'b1; end
      DIR_SW:  begin down = 1'b1; left = 1'b1;  end
      DIR_NW:  begin up = 1'b1;   left = 1'b1;  end
      default: ;
    endcase
    r = rank_of(square);
    f = file_of(square);
    off_board = (up && r == 3'd7) || (down && r == 3'd0) ||
                (right && f == 3'd7) || (left && f == 3'd0);
    next_square = {up ? r + 3'd1 : (down ? r - 3'd1 : r),
                   right ? f + 3'd1 : (left ? f - 3'd1 : f)};
  end

endmodule

// File: rtl/attack_map_gen.sv
// Sequential attack-map generator: scans the 64 squares one per cycle and
// walks slider rays one step per cycle, then strobes the finished bitboard.
module attack_map_gen
  import board_pkg::*;
#(
  parameter int SIDE_WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [255:0] board,
  input  logic         color,
  input  logic         board_valid,
  output logic         busy,
  output logic [63:0]  attacked,
  output logic         attacked_valid
);

  localparam logic [5:0] LAST_SQ = 6'(SIDE_WIDTH * SIDE_WIDTH - 1);

  state_e       state_q, state_d;
  logic [5:0]   cursor_q, cursor_d;
  logic [5:0]   ray_pos_q, ray_pos_d;
  dir_e         dir_q, dir_d;
  logic [63:0]  attacked_d;
  logic [255:0] board_q;
  logic         color_q;

  logic [3:0]   piece;
  logic [2:0]   kind;
  logic         own;
  logic         slider;
  dir_e         last_dir;
  logic [5:0]   step_sq;
  logic         step_off;
  logic [2:0]   target_kind;
  logic         dir_end;

  // NOTE: the latched position is pure data qualified by state, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && board_valid) begin
      board_q <= board;
      color_q <= color;
    end
  end

  square_step u_step (
    .square      (ray_pos_q),
    .dir         (dir_q),
    .next_square (step_sq),
    .off_board   (step_off)
  );

  // The cursor keeps pointing at the slider while its rays are walked.
  assign piece       = board_q[{cursor_q, 2'b00} +: PIECE_W];
  assign kind        = piece[2:0];
  assign own         = (piece[COLOR_BIT] == color_q);
  assign slider      = own && (kind == BISHOP || kind == ROOK || kind == QUEEN);
  assign last_dir    = (kind == ROOK) ? DIR_W : DIR_NW;
  assign target_kind = board_q[{step_sq, 2'b00} +: 3];

  always_comb begin
    state_d    = state_q;
    cursor_d   = cursor_q;
    ray_pos_d  = ray_pos_q;
    dir_d      = dir_q;
    attacked_d = attacked;
    dir_end    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (board_valid) begin
          state_d    = ST_SCAN;
          cursor_d   = '0;
          attacked_d = '0;
        end
      end
      ST_SCAN: begin
        if (slider) begin
          state_d   = ST_RAY;
          ray_pos_d = cursor_q;
          dir_d     = (kind == BISHOP) ? DIR_NE : DIR_N;
        end else begin
          if (own) attacked_d = attacked | leaper_mask(cursor_q, kind, color_q);
          if (cursor_q == LAST_SQ) state_d = ST_DONE;
          else                     cursor_d = cursor_q + 6'd1;
        end
      end
      ST_RAY: begin
        if (step_off) begin
          dir_end = 1'b1;
        end else begin
          attacked_d[step_sq] = 1'b1;
          if (is_piece(target_kind)) dir_end = 1'b1;
          else                       ray_pos_d = step_sq;
        end
        if (dir_end) begin
          ray_pos_d = cursor_q;
          if (dir_q == last_dir) begin
            if (cursor_q == LAST_SQ) begin
              state_d = ST_DONE;
            end else begin
              state_d  = ST_SCAN;
              cursor_d = cursor_q + 6'd1;
            end
          end else begin
            dir_d = dir_e'(dir_q + 3'd1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cursor_q  <= '0;
      ray_pos_q <= '0;
      dir_q     <= DIR_N;
      attacked  <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      ray_pos_q <= ray_pos_d;
      dir_q     <= dir_d;
      attacked  <= attacked_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign attacked_valid = (state_q == ST_DONE);

endmodule

// File: tb/tb_attack_map_gen.sv
// Directed bench for attack_map_gen: latency, maps, busy window, request
// handling while busy and reset during a ray walk.
module tb_attack_map_gen;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [255:0] board;
  logic         color;
  logic         board_valid;
  logic         busy;
  logic [63:0]  attacked;
  logic         attacked_valid;

  int checks = 0;
  int errors = 0;

  attack_map_gen #(.SIDE_WIDTH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .board          (board),
    .color          (color),
    .board_valid    (board_valid),
    .busy           (busy),
    .attacked       (attacked),
    .attacked_valid (attacked_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] place(input logic [255:0] b, input int sq,
                                         input logic [3:0] code);
    logic [255:0] r;
    r = b;
    r[sq*4 +: 4] = code;
    return r;
  endfunction

  // Issues one request and waits (bounded) for the strobe; n counts edges after accept.
  task automatic run_request(input logic [255:0] b, input logic c, output int lat,
                             output logic [63:0] map, output bit busy_ok,
                             output bit clean_end);
    @(negedge clk);
    board = b;
    color = c;
    board_valid = 1'b1;
    @(posedge clk);
    lat = -1;
    busy_ok = 1'b1;
    map = '0;
    for (int n = 1; n <= 200 && lat < 0; n++) begin
      @(negedge clk);
      board_valid = 1'b0;
      if (!busy) busy_ok = 1'b0;
      if (attacked_valid) begin
        lat = n;
        map = attacked;
      end
    end
    @(negedge clk);
    clean_end = !busy && !attacked_valid && (attacked === map);
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    board = '0;
    color = 1'b0;
    board_valid = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (attacked_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", attacked_valid); end
    checks++;
    if (attacked !== 64'h0) begin errors++; $display("FAIL reset_attacked got %h want 0", attacked); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    int lat; logic [63:0] map; bit busy_ok, clean;
    run_request('0, 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL empty_latency got %0d want 65", lat); end
    checks++;
    if (map !== 64'h0) begin errors++; $display("FAIL empty_map got %h want 0", map); end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL empty_busy_window got low want high T+1..strobe"); end
    checks++;
    if (!clean) begin errors++; $display("FAIL empty_after_strobe got busy=%b valid=%b want 0 0", busy, attacked_valid); end
  endtask

  task automatic test_knight();
    int lat; logic [63:0] map; bit busy_ok, clean;
    run_request(place('0, 1, 4'h2), 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL knight_latency got %0d want 65", lat); end
    checks++;
    if (map !== 64'h0000_0000_0005_0800) begin errors++; $display("FAIL knight_map got %h want 0000000000050800", map); end
  endtask

  task automatic test_rook();
    int lat; logic [63:0] map; bit busy_ok, clean;
    run_request(place('0, 0, 4'h4), 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (lat !== 83) begin errors++; $display("FAIL rook_latency got %0d want 83", lat); end
    checks++;
    if (map !== 64'h0101_0101_0101_01FE) begin errors++; $display("FAIL rook_map got %h want 01010101010101fe", map); end
    checks++;
    if (!busy_ok || !clean) begin errors++; $display("FAIL rook_handshake got busy_ok=%b clean=%b want 1 1", busy_ok, clean); end
  endtask

  task automatic test_rook_blocked();
    int lat; logic [63:0] map; bit busy_ok, clean;
    run_request(place(place('0, 0, 4'h4), 24, 4'h9), 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (lat !== 78) begin errors++; $display("FAIL rook_blocked_latency got %0d want 78", lat); end
    checks++;
    if (map !== 64'h0000_0000_0101_01FE) begin errors++; $display("FAIL rook_blocked_map got %h want 00000000010101fe", map); end
  endtask

  task automatic test_pawns();
    int lat; logic [63:0] map; bit busy_ok, clean;
    logic [255:0] b;
    b = place(place('0, 15, 4'h1), 52, 4'h9);
    run_request(b, 1'b1, lat, map, busy_ok, clean);
    checks++;
    if (map !== 64'h0000_2800_0000_0000) begin errors++; $display("FAIL pawn_black_map got %h want 0000280000000000", map); end
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL pawn_black_latency got %0d want 65", lat); end
    run_request(b, 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (map !== 64'h0000_0000_0040_0000) begin errors++; $display("FAIL pawn_white_nowrap_map got %h want 0000000000400000", map); end
    checks++;
    if (lat !== 65) begin errors++; $display("FAIL pawn_white_latency got %0d want 65", lat); end
  endtask

  // board_valid held high: the busy-time request is dropped, then re-accepted right after the strobe.
  task automatic test_back_to_back();
    int first, second, count;
    logic gap_busy;
    first = -1; second = -1; count = 0; gap_busy = 1'b1;
    @(negedge clk);
    board = '0;
    color = 1'b0;
    board_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 140; n++) begin
      @(negedge clk);
      if (n == 66) gap_busy = busy;
      if (attacked_valid) begin
        count++;
        if (first < 0) first = n;
        else if (second < 0) begin
          second = n;
          board_valid = 1'b0;
        end
      end
    end
    board_valid = 1'b0;
    checks++;
    if (first !== 65) begin errors++; $display("FAIL b2b_first_strobe got %0d want 65", first); end
    checks++;
    if (second !== 131) begin errors++; $display("FAIL b2b_second_strobe got %0d want 131", second); end
    checks++;
    if (count !== 2) begin errors++; $display("FAIL b2b_strobe_count got %0d want 2", count); end
    checks++;
    if (gap_busy !== 1'b0) begin errors++; $display("FAIL b2b_gap_busy got %b want 0", gap_busy); end
  endtask

  task automatic test_reset_mid_ray();
    int lat, strobes; logic [63:0] map; bit busy_ok, clean;
    logic mid_busy;
    @(negedge clk);
    board = place('0, 0, 4'h4);
    color = 1'b0;
    board_valid = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      board_valid = 1'b0;
    end
    mid_busy = busy;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mid_busy !== 1'b1) begin errors++; $display("FAIL midray_busy_before got %b want 1", mid_busy); end
    checks++;
    if (busy !== 1'b0 || attacked_valid !== 1'b0 || attacked !== 64'h0) begin
      errors++;
      $display("FAIL midray_reset_outputs got busy=%b valid=%b map=%h want 0 0 0", busy, attacked_valid, attacked);
    end
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    repeat (100) begin
      @(negedge clk);
      if (attacked_valid) strobes++;
    end
    checks++;
    if (strobes !== 0) begin errors++; $display("FAIL midray_no_strobe got %0d want 0", strobes); end
    run_request(place('0, 1, 4'h2), 1'b0, lat, map, busy_ok, clean);
    checks++;
    if (lat !== 65 || map !== 64'h0000_0000_0005_0800) begin
      errors++;
      $display("FAIL midray_recovery got lat=%0d map=%h want 65 0000000000050800", lat, map);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_knight();
    test_rook();
    test_rook_blocked();
    test_pawns();
    test_back_to_back();
    test_reset_mid_ray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
